// File: rtl/snes_joy_pkg.sv
// rtl/snes_joy_pkg.sv - shared constants and types for the SNES controller-port emulator
package snes_joy_pkg;

  localparam int BTN_NUM  = 12;
  localparam int PAD_BITS = 16;
  localparam logic [3:0] PAD_ID = 4'b1111;

  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  typedef logic [BTN_NUM-1:0]  pad_btn_t;
  typedef logic [PAD_BITS-1:0] pad_word_t;

  // Serial word as the console sees it: low = pressed, ID nibble always released.
  function automatic pad_word_t pad_latch(input pad_btn_t eff);
    return {PAD_ID, ~eff};
  endfunction

endpackage

// File: rtl/snes_joy_debounce.sv
// rtl/snes_joy_debounce.sv - 2-FF sync plus sampled two-agreement debounce for all buttons
module snes_joy_debounce #(
  parameter int WIDTH           = 24,
  parameter int DEBOUNCE_CYCLES = 21477
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0]    presc;
  logic             tick;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] agree;

  assign tick  = (presc == TERM);
  assign agree = ~(sync2 ^ prev);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      state <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      presc <= tick ? '0 : presc + CW'(1);
      if (tick) begin
        prev  <= sync2;
        // A bit only moves when this sample matches the previous one.
        state <= (sync2 & agree) | (state & ~agree);
      end
    end
  end

endmodule

// File: rtl/snes_joy_serializer.sv
// rtl/snes_joy_serializer.sv - multi-pad SNES serial port emulator with debounce
// Optional turbo when SNES_JOY_TURBO_EN is defined.
module snes_joy_serializer
  import snes_joy_pkg::*;
#(
  parameter int NUM_PADS        = 2,
  parameter int DEBOUNCE_CYCLES = 21477,
  parameter int TURBO_DIV       = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [BTN_NUM*NUM_PADS-1:0] btn_in,
  input  logic [BTN_NUM*NUM_PADS-1:0] turbo_mask,
  input  logic                        joy_strb,
  input  logic [NUM_PADS-1:0]         joy_clk,
  output logic [NUM_PADS-1:0]         joy_di,
  output logic [BTN_NUM*NUM_PADS-1:0] btn_state
);

  localparam int W = BTN_NUM * NUM_PADS;

  logic [W-1:0] eff;

  snes_joy_debounce #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .reset(reset),
    .raw  (btn_in),
    .state(btn_state)
  );

`ifdef SNES_JOY_TURBO_EN
  localparam int TW = $clog2(TURBO_DIV + 1);

  logic          strb_q;
  logic          strb_rise;
  logic [TW-1:0] turbo_cnt;
  logic          turbo_phase;

  assign strb_rise = joy_strb & ~strb_q;

  // Counter runs 1..TURBO_DIV; the phase flips at the start of a frame so
  // every strobe cycle of one frame reloads with the same phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strb_q      <= 1'b0;
      turbo_cnt   <= '0;
      turbo_phase <= 1'b0;
    end else begin
      strb_q <= joy_strb;
      if (strb_rise) begin
        if (turbo_cnt == TW'(TURBO_DIV)) begin
          turbo_cnt   <= TW'(1);
          turbo_phase <= ~turbo_phase;
        end else begin
          turbo_cnt <= turbo_cnt + TW'(1);
        end
      end
    end
  end

  assign eff = btn_state & ~(turbo_mask & {W{turbo_phase}});
`else
  logic turbo_unused;

  assign turbo_unused = ^turbo_mask;
  assign eff          = btn_state;
`endif

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    pad_word_t sr;
    logic      clk_q;
    logic      clk_rise;

    assign clk_rise = joy_clk[p] & ~clk_q;

    // Strobe is level-sensitive and beats a coincident clock edge.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sr    <= '1;
        clk_q <= 1'b1;
      end else begin
        clk_q <= joy_clk[p];
        if (joy_strb) begin
          sr <= pad_latch(eff[BTN_NUM*p +: BTN_NUM]);
        end else if (clk_rise) begin
          sr <= {1'b0, sr[PAD_BITS-1:1]};
        end
      end
    end

    assign joy_di[p] = sr[0];
  end

endmodule

// File: tb/tb_snes_joy_serializer.sv
// tb/tb_snes_joy_serializer.sv - directed vector bench for snes_joy_serializer
module tb_snes_joy_serializer;

  localparam int NP = 2;
  localparam int DC = 4;
  localparam int TD = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] btn_in = '0;
  logic [23:0] turbo_mask = '0;
  logic        joy_strb = 1'b0;
  logic [1:0]  joy_clk = 2'b11;
  logic [1:0]  joy_di;
  logic [23:0] btn_state;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [11:0] b0;
    logic [11:0] b1;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;

  vec_t vecs[4];

  snes_joy_serializer #(
    .NUM_PADS       (NP),
    .DEBOUNCE_CYCLES(DC),
    .TURBO_DIV      (TD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .turbo_mask(turbo_mask),
    .joy_strb  (joy_strb),
    .joy_clk   (joy_clk),
    .joy_di    (joy_di),
    .btn_state (btn_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    joy_clk = 2'b11;
    @(negedge clk);
    joy_clk = 2'b00;
    @(negedge clk);
  endtask

  task automatic strobe();
    joy_strb = 1'b1;
    step(2);
    joy_strb = 1'b0;
  endtask

  task automatic read(input int nbits, output logic [31:0] s0, output logic [31:0] s1);
    s0 = '0;
    s1 = '0;
    for (int i = 0; i < nbits; i++) begin
      s0[i] = joy_di[0];
      s1[i] = joy_di[1];
      pulse();
    end
  endtask

  initial begin
    logic [31:0] s0, s1;
    logic        seen;
    int          lat;
    logic [7:0]  turbo_exp;

    vecs[0] = '{12'h081, 12'h000, 16'hFF7E, 16'hFFFF};
    vecs[1] = '{12'h000, 12'hF00, 16'hFFFF, 16'hF0FF};
    vecs[2] = '{12'hFFF, 12'h018, 16'hF000, 16'hFFE7};
    vecs[3] = '{12'h006, 12'h060, 16'hFFF9, 16'hFF9F};

    // Reset release with joy_clk held high must not count as an edge.
    step(3);
    reset = 1'b0;
    step(2);
    check("reset_di", 32'(joy_di), 32'h3);
    check("reset_btn_state", 32'(btn_state), 32'h0);
    joy_clk = 2'b00;
    step(1);
    repeat (15) pulse();
    check("no_edge_at_release", 32'(joy_di), 32'h3);
    pulse();
    check("sixteenth_shift_zero", 32'(joy_di), 32'h0);

    for (int v = 0; v < 4; v++) begin
      btn_in = {vecs[v].b1, vecs[v].b0};
      step(20);
      check($sformatf("vec%0d_btn_state", v), 32'(btn_state), 32'({vecs[v].b1, vecs[v].b0}));
      strobe();
      read(16, s0, s1);
      check($sformatf("vec%0d_pad0", v), s0, 32'(vecs[v].e0));
      check($sformatf("vec%0d_pad1", v), s1, 32'(vecs[v].e1));
    end

    // Bounce: Up toggles every sample period so successive samples disagree.
    btn_in = '0;
    step(20);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      btn_in[4] = ((k / DC) % 2) == 1;
      step(1);
      if (btn_state[4] !== 1'b0) seen = 1'b1;
    end
    check("bounce_rejected", 32'(seen), 32'h0);
    btn_in[4] = 1'b1;
    lat = 0;
    while (btn_state[4] !== 1'b1 && lat < 40) begin
      step(1);
      lat++;
    end
    check("debounce_accept", 32'(btn_state[4]), 32'h1);
    check("debounce_latency", 32'(lat <= 2 * DC + 3), 32'h1);
    btn_in[4] = 1'b0;
    step(20);

    // Over-clock: edges beyond 16 shift in zeros.
    btn_in = {12'h000, 12'h081};
    step(20);
    strobe();
    read(20, s0, s1);
    check("overclock_pad0_bits", 32'(s0[15:0]), 32'hFF7E);
    check("overclock_pad0_tail", 32'(s0[19:16]), 32'h0);
    check("overclock_pad1_tail", 32'(s1[19:16]), 32'h0);

    // Collision: strobe and clock edge in the same cycle, strobe wins.
    btn_in = {12'h000, 12'h080};
    step(20);
    joy_strb = 1'b1;
    joy_clk  = 2'b11;
    @(negedge clk);
    check("collision_bit0", 32'(joy_di), 32'h3);
    joy_strb = 1'b0;
    joy_clk  = 2'b00;
    step(1);
    read(16, s0, s1);
    check("collision_pad0", s0, 32'hFF7F);
    check("collision_pad1", s1, 32'hFFFF);

    // Mid-read reset, then a fresh read.
    btn_in = {12'h100, 12'h081};
    step(20);
    strobe();
    repeat (5) pulse();
    reset = 1'b1;
    #1;
    check("midread_reset_di", 32'(joy_di), 32'h3);
    check("midread_reset_state", 32'(btn_state), 32'h0);
    step(2);
    reset = 1'b0;
    step(1);
    check("post_reset_idle_di", 32'(joy_di), 32'h3);
    step(20);
    strobe();
    read(16, s0, s1);
    check("post_reset_pad0", s0, 32'hFF7E);
    check("post_reset_pad1", s1, 32'hFEFF);

    // Turbo on Y: frames read pressed, pressed, released, released, ...
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    btn_in     = {12'h000, 12'h002};
    turbo_mask = {12'h000, 12'h002};
    step(20);
`ifdef SNES_JOY_TURBO_EN
    turbo_exp = 8'b1100_1100;
`else
    turbo_exp = 8'b0000_0000;
`endif
    for (int f = 0; f < 8; f++) begin
      strobe();
      read(16, s0, s1);
      check($sformatf("turbo_frame%0d_y", f), 32'(s0[1]), 32'(turbo_exp[f]));
      step(2);
    end
    check("turbo_btn_state", 32'(btn_state), 32'h000002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
